alarm_responder: RTL and testbench
==================================

Name: alarm_responder

Overview:
Consumer end of the alarm-compare interface. Detects the rising edge of ALARM_DOING and drives the piezo with a gated square-wave tone in a beep cadence. Services user STOP and SNOOZE pulses; a snooze schedules its own re-ring at CURRENT_TIME + SNOOZE_SEC, with wrap at midnight. Sits between the time-compare block and the piezo pin / LED status in the alarm-clock top level.

Parameters:
TONE_HALF, 25, CLK cycles per tone half-period (2 kHz at the 100 kHz system clock)
BEEP_ON, 50000, CLK cycles the tone is gated on per cadence period
BEEP_OFF, 50000, CLK cycles the tone is gated off per cadence period
RING_CYC, 3000000, CLK cycles before an unattended ring auto-stops (30 s)
SNOOZE_SEC, 300, seconds added to CURRENT_TIME on snooze; must be < DAY_SEC
MAX_SNOOZE, 3, snoozes allowed per alarm event
DAY_SEC, 86400, seconds per day; CURRENT_TIME range is 0..DAY_SEC-1

Ports:
CLK  in  1  system clock; the single clock
RESET  in  1  synchronous, active-high reset
ALARM_DOING  in  1  level from time-compare; a rising edge starts a ring
CURRENT_TIME  in  17  seconds of day, 0..86399
STOP_BTN  in  1  debounced one-cycle pulse
SNOOZE_BTN  in  1  debounced one-cycle pulse
PIEZO  out  1  tone output
RINGING  out  1  high while in RING
SNOOZE_PENDING  out  1  high while in SNOOZE
SNOOZE_LEFT  out  2  remaining snoozes
ALARM_ACK  out  1  one-cycle pulse when a ring ends by STOP or timeout

Behaviour:
- Reset, applied at any cycle: state IDLE; PIEZO=0, RINGING=0, SNOOZE_PENDING=0, ALARM_ACK=0, SNOOZE_LEFT=MAX_SNOOZE; all counters=0; the edge-detect register loads the current ALARM_DOING, so a level that is already high does not ring.
- Edge detect: rise = ALARM_DOING & ~doing_q, registered each cycle.
- States:
  - IDLE: on rise, go to RING, SNOOZE_LEFT=MAX_SNOOZE, clear counters.
  - RING: on STOP_BTN, go to IDLE and pulse ACK. Else on SNOOZE_BTN with SNOOZE_LEFT>0, latch wake time, decrement SNOOZE_LEFT, go to SNOOZE. On SNOOZE_BTN with SNOOZE_LEFT==0, treat it as STOP. When ring_cnt==RING_CYC-1, go to IDLE and pulse ACK.
  - SNOOZE: when CURRENT_TIME==wake, go to RING and clear counters. On STOP_BTN, go to IDLE without an ACK pulse. On rise, which is a new alarm, go to RING and restore SNOOZE_LEFT=MAX_SNOOZE.
- Priority inside RING: STOP > SNOOZE > timeout; all three fire on the same cycle they arrive.
- Wake time: sum = CURRENT_TIME + SNOOZE_SEC, computed at 18 bits. If sum >= DAY_SEC, wake = sum - DAY_SEC; else wake = sum. Latched once at snooze entry.
- Counters clear on RING entry and run only in RING:
  - tone counter 0..TONE_HALF-1 toggles tone_q at terminal count;
  - cadence counter 0..BEEP_ON+BEEP_OFF-1, where gate = (cad < BEEP_ON);
  - ring_cnt 0..RING_CYC-1.
- PIEZO = tone_q & gate & RINGING. The output is registered and begins with gate on at the first RING cycle. PIEZO is 0 in every other state, immediately on exit.
- Latency: rise seen at cycle n → RINGING=1 at n+1. A button at cycle n → state change visible at n+1. ALARM_ACK is high for exactly that n+1 cycle.
- ALARM_DOING falling has no effect on state. Rings end only by STOP, SNOOZE or timeout.
- Button pulses outside RING and SNOOZE are ignored.

Decomposition:
- Shared package alarm_pkg:
  - state enum {IDLE, RING, SNOOZE};
  - DAY_SEC constant;
  - 17-bit time_t typedef, also used by the time-compare and clock-counter blocks.
- One natural sub-module, tone_gen: the tone and cadence counters, with enable/clear in and PIEZO out. The FSM and wake arithmetic stay in the top.

Test Plan:
Use TONE_HALF=2, BEEP_ON=8, BEEP_OFF=8, RING_CYC=40 for every scenario.
1. ALARM_DOING 0→1 at cycle 10 → RINGING=1 at cycle 11. PIEZO toggles every 2 cycles for 8 cycles, then stays 0 for 8. With no buttons, RINGING falls after 40 cycles and ALARM_ACK pulses once.
2. Ringing, STOP_BTN pulse → next cycle RINGING=0, PIEZO=0, ALARM_ACK=1 for exactly one cycle. Holding ALARM_DOING high afterwards does not re-ring.
3. Ringing with CURRENT_TIME=86300, SNOOZE_BTN → SNOOZE_PENDING=1, SNOOZE_LEFT=2, wake=200. Step time through 86399→0→200 → RINGING=1 the cycle after CURRENT_TIME=200.
4. Four successive snooze cycles → the fourth SNOOZE_BTN acts as STOP: IDLE, ALARM_ACK pulses, SNOOZE_LEFT=0. A new ALARM_DOING rise restores SNOOZE_LEFT=3.
5. STOP_BTN and SNOOZE_BTN in the same ringing cycle → IDLE and ALARM_ACK. SNOOZE_LEFT is unchanged and SNOOZE_PENDING=0.
6. RESET asserted mid-ring with PIEZO=1 → next cycle all outputs are at their reset values. After deassert, a still-high ALARM_DOING does not ring; a fresh 0→1 edge does.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types for the alarm-clock datapath: FSM states, day length and
// the seconds-of-day time type used by the compare and counter blocks.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    localparam int DAY_SEC = 86400;

    typedef logic [16:0] time_t;

endpackage

// File: rtl/tone_gen.sv
// Tone and cadence generator: a square wave gated by a beep on/off cadence.
// Counters are held at zero while disabled, so every ring restarts the
// pattern with the gate on and the tone phase low.
module tone_gen
    import alarm_pkg::*;
#(
    parameter int TONE_HALF = 25,
    parameter int BEEP_ON   = 50000,
    parameter int BEEP_OFF  = 50000
) (
    input  logic CLK,
    input  logic i_rst,
    input  logic i_en,
    output logic o_piezo
);

    localparam int CAD_LEN = BEEP_ON + BEEP_OFF;
    localparam int TW      = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int CW      = (CAD_LEN > 1) ? $clog2(CAD_LEN) : 1;

    logic [TW-1:0] r_tone_cnt;
    logic          r_tone_q;
    logic [CW-1:0] r_cad_cnt;
    logic          w_gate;

    // Tone half-period and cadence counters; cleared whenever not ringing.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (i_rst || !i_en) begin
            r_tone_cnt <= '0;
            r_tone_q   <= 1'b0;
            r_cad_cnt  <= '0;
        end else begin
            if (r_tone_cnt == TW'(TONE_HALF - 1)) begin
                r_tone_cnt <= '0;
                r_tone_q   <= ~r_tone_q;
            end else begin
                r_tone_cnt <= r_tone_cnt + 1'b1;
            end
            if (r_cad_cnt == CW'(CAD_LEN - 1)) begin
                r_cad_cnt <= '0;
            end else begin
                r_cad_cnt <= r_cad_cnt + 1'b1;
            end
        end
    end

    assign w_gate  = (r_cad_cnt < CW'(BEEP_ON));
    // Built only from flops and the enable, so it drops the cycle RING ends.
    assign o_piezo = r_tone_q & w_gate & i_en;

endmodule

// File: rtl/alarm_responder.sv
// Alarm responder: rings on a rising ALARM_DOING, services STOP/SNOOZE,
// schedules snooze re-rings with midnight wrap, and auto-stops a ring.
module alarm_responder
    import alarm_pkg::*;
#(
    parameter int TONE_HALF  = 25,
    parameter int BEEP_ON    = 50000,
    parameter int BEEP_OFF   = 50000,
    parameter int RING_CYC   = 3000000,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ALARM_DOING,
    input  logic [16:0] CURRENT_TIME,
    input  logic        STOP_BTN,
    input  logic        SNOOZE_BTN,
    output logic        PIEZO,
    output logic        RINGING,
    output logic        SNOOZE_PENDING,
    output logic [1:0]  SNOOZE_LEFT,
    output logic        ALARM_ACK
);

    localparam int RW = (RING_CYC > 1) ? $clog2(RING_CYC) : 1;

    state_t        r_state;
    logic          r_doing_q;
    logic [1:0]    r_snooze_left;
    logic          r_ack;
    time_t         r_wake;
    logic [RW-1:0] r_ring_cnt;

    logic          w_rise;
    logic [17:0]   w_sum;
    time_t         w_wake;
    logic          w_timeout;

    assign w_rise    = ALARM_DOING & ~r_doing_q;
    assign w_sum     = 18'(CURRENT_TIME) + 18'(SNOOZE_SEC);
    assign w_wake    = (w_sum >= 18'(DAY_SEC)) ? time_t'(w_sum - 18'(DAY_SEC))
                                                : w_sum[16:0];
    assign w_timeout = (r_ring_cnt == RW'(RING_CYC - 1));

    // Edge-detect history; loaded even during reset so a level that is
    // already high when reset releases is not mistaken for a new alarm.
    always_ff @(posedge CLK) begin
        r_doing_q <= ALARM_DOING;
    end

    // Responder FSM with registered status, ACK pulse, wake time and ring timer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_snooze_left <= 2'(MAX_SNOOZE);
            r_ack         <= 1'b0;
            r_wake        <= '0;
            r_ring_cnt    <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state       <= RING;
                        r_snooze_left <= 2'(MAX_SNOOZE);
                        r_ring_cnt    <= '0;
                    end
                end
                RING: begin
                    // An exhausted snooze budget turns SNOOZE into STOP.
                    if (STOP_BTN || (SNOOZE_BTN && r_snooze_left == 2'd0)) begin
                        r_state <= IDLE;
                        r_ack   <= 1'b1;
                    end else if (SNOOZE_BTN) begin
                        r_state       <= SNOOZE;
                        r_snooze_left <= r_snooze_left - 2'd1;
                        r_wake        <= w_wake;
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                        r_ack   <= 1'b1;
                    end else begin
                        r_ring_cnt <= r_ring_cnt + 1'b1;
                    end
                end
                SNOOZE: begin
                    // User STOP wins, then a fresh alarm, then the snooze wake-up.
                    if (STOP_BTN) begin
                        r_state <= IDLE;
                    end else if (w_rise) begin
                        r_state       <= RING;
                        r_snooze_left <= 2'(MAX_SNOOZE);
                        r_ring_cnt    <= '0;
                    end else if (CURRENT_TIME == r_wake) begin
                        r_state    <= RING;
                        r_ring_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign RINGING        = (r_state == RING);
    assign SNOOZE_PENDING = (r_state == SNOOZE);
    assign SNOOZE_LEFT    = r_snooze_left;
    assign ALARM_ACK      = r_ack;

    tone_gen #(
        .TONE_HALF (TONE_HALF),
        .BEEP_ON   (BEEP_ON),
        .BEEP_OFF  (BEEP_OFF)
    ) u_tone_gen (
        .CLK     (CLK),
        .i_rst   (RESET),
        .i_en    (RINGING),
        .o_piezo (PIEZO)
    );

endmodule

// File: tb/tb_alarm_responder.sv
// Testbench for alarm_responder: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model.
module tb_alarm_responder;

    localparam int TH   = 2;
    localparam int BON  = 8;
    localparam int BOFF = 8;
    localparam int RCYC = 40;
    localparam int SSEC = 300;
    localparam int MAXS = 3;
    localparam int DAY  = 86400;

    logic        clk;
    logic        rst;
    logic        doing;
    logic [16:0] cur_time;
    logic        stop_btn;
    logic        snooze_btn;
    logic        piezo;
    logic        ringing;
    logic        snooze_pending;
    logic [1:0]  snooze_left;
    logic        alarm_ack;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: plain status flags, a ring age and arithmetic wake time.
    bit m_ringing, m_snoozing, m_ack, m_prev;
    int m_left, m_wake, m_age;

    alarm_responder #(
        .TONE_HALF  (TH),
        .BEEP_ON    (BON),
        .BEEP_OFF   (BOFF),
        .RING_CYC   (RCYC),
        .SNOOZE_SEC (SSEC),
        .MAX_SNOOZE (MAXS)
    ) dut (
        .CLK            (clk),
        .RESET          (rst),
        .ALARM_DOING    (doing),
        .CURRENT_TIME   (cur_time),
        .STOP_BTN       (stop_btn),
        .SNOOZE_BTN     (snooze_btn),
        .PIEZO          (piezo),
        .RINGING        (ringing),
        .SNOOZE_PENDING (snooze_pending),
        .SNOOZE_LEFT    (snooze_left),
        .ALARM_ACK      (alarm_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit rise;
        int t;
        t = int'(cur_time);
        if (rst) begin
            m_ringing = 0; m_snoozing = 0; m_ack = 0;
            m_left = MAXS; m_age = 0; m_wake = 0;
            m_prev = doing;
            return;
        end
        rise   = doing && !m_prev;
        m_prev = doing;
        m_ack  = 0;
        if (m_ringing) begin
            if (stop_btn || (snooze_btn && m_left == 0)) begin
                m_ringing = 0; m_ack = 1;
            end else if (snooze_btn) begin
                m_ringing = 0; m_snoozing = 1; m_left--;
                m_wake = (t + SSEC) % DAY;
            end else if (m_age == RCYC - 1) begin
                m_ringing = 0; m_ack = 1;
            end else begin
                m_age++;
            end
        end else if (m_snoozing) begin
            if (stop_btn) begin
                m_snoozing = 0;
            end else if (rise) begin
                m_snoozing = 0; m_ringing = 1; m_left = MAXS; m_age = 0;
            end else if (t == m_wake) begin
                m_snoozing = 0; m_ringing = 1; m_age = 0;
            end
        end else if (rise) begin
            m_ringing = 1; m_left = MAXS; m_age = 0;
        end
    endtask

    function automatic bit exp_piezo();
        return m_ringing && (((m_age / TH) % 2) == 1) && ((m_age % (BON + BOFF)) < BON);
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check("ringing", 32'(ringing), 32'(m_ringing));
        check("snooze_pending", 32'(snooze_pending), 32'(m_snoozing));
        check("snooze_left", 32'(snooze_left), 32'(m_left));
        check("alarm_ack", 32'(alarm_ack), 32'(m_ack));
        check("piezo", 32'(piezo), 32'(exp_piezo()));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_stop();
        stop_btn = 1'b1; tick(); stop_btn = 1'b0;
    endtask

    task automatic pulse_snooze();
        snooze_btn = 1'b1; tick(); snooze_btn = 1'b0;
    endtask

    initial begin
        int t;
        int r;
        rst = 1'b1; doing = 1'b0; cur_time = '0;
        stop_btn = 1'b0; snooze_btn = 1'b0;
        #1;
        ticks(2);
        check("reset_left", 32'(snooze_left), 32'(MAXS));
        rst = 1'b0;

        // 1: rise at cycle 10, full tone/cadence pattern, timeout with ACK.
        ticks(8);
        doing = 1'b1;
        tick();
        check("s1_ring_start", 32'(ringing), 32'd1);
        ticks(RCYC + 5);
        doing = 1'b0;
        tick();

        // 2: STOP mid-ring; held level must not re-ring.
        doing = 1'b1;
        ticks(6);
        pulse_stop();
        check("s2_ack", 32'(alarm_ack), 32'd1);
        ticks(20);
        doing = 1'b0;
        tick();

        // 3: snooze just before midnight, wake wraps to 200.
        cur_time = 17'd86300;
        doing = 1'b1;
        ticks(4);
        pulse_snooze();
        check("s3_pending", 32'(snooze_pending), 32'd1);
        check("s3_left", 32'(snooze_left), 32'd2);
        t = 86300;
        for (int i = 0; i < 301; i++) begin
            t = (t + 1) % DAY;
            cur_time = 17'(t);
            tick();
        end
        check("s3_rering", 32'(ringing), 32'd1);
        pulse_stop();

        // 4: exhaust snoozes; fourth acts as STOP; new rise restores budget.
        doing = 1'b0; tick();
        doing = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin
            ticks(2);
            pulse_snooze();
            if (i < 3) begin
                t = (t + SSEC) % DAY;
                cur_time = 17'(t);
                tick();
            end
        end
        check("s4_left_zero", 32'(snooze_left), 32'd0);
        check("s4_ack", 32'(alarm_ack), 32'd1);
        doing = 1'b0; tick();
        doing = 1'b1; tick();
        check("s4_left_restored", 32'(snooze_left), 32'(MAXS));

        // 5: STOP and SNOOZE together.
        ticks(2);
        stop_btn = 1'b1; snooze_btn = 1'b1;
        tick();
        stop_btn = 1'b0; snooze_btn = 1'b0;
        check("s5_pending", 32'(snooze_pending), 32'd0);

        // 6: reset mid-ring while the tone is high.
        doing = 1'b0; tick();
        doing = 1'b1; ticks(3);
        check("s6_piezo_high", 32'(piezo), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("s6_piezo_reset", 32'(piezo), 32'd0);
        ticks(5);
        doing = 1'b0; tick();
        doing = 1'b1; tick();
        check("s6_fresh_ring", 32'(ringing), 32'd1);

        // Random traffic: time mostly advances one second per cycle.
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 15) doing = ~doing;
            stop_btn   = ($urandom_range(0, 59) == 0);
            snooze_btn = ($urandom_range(0, 24) == 0);
            rst        = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 199) == 0) t = int'($urandom_range(0, DAY - 1));
            else t = (t + 1) % DAY;
            cur_time = 17'(t);
            tick();
        end
        rst = 1'b0; stop_btn = 1'b0; snooze_btn = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
